// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: Tuse/Tnew class constants, the ID/EX bundle
// and the operand bypass priority helper.
package mips_pipe_pkg;

    // Tuse value meaning "operand not consumed"
    localparam logic [1:0] TUSE_NONE     = 2'd3;

    // Per-class Tnew (cycles after entering EX until forwardable)
    localparam logic [1:0] TNEW_ALU      = 2'd1;
    localparam logic [1:0] TNEW_LOAD     = 2'd2;

    // Per-class Tuse (cycles after ID until the operand is consumed)
    localparam logic [1:0] TUSE_BRANCH   = 2'd0;
    localparam logic [1:0] TUSE_ALU      = 2'd1;
    localparam logic [1:0] TUSE_STORE_RT = 2'd2;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  a3;
        logic [1:0]  tnew;
    } id_ex_t;

    // Youngest in-flight result wins; $0 always reads as zero
    function automatic logic [31:0] bypass(
        input logic [4:0]  src,
        input logic [31:0] grf,
        input logic        e_we,
        input logic [4:0]  e_a3,
        input logic [31:0] e_wd,
        input logic        m_we,
        input logic [4:0]  m_a3,
        input logic [31:0] m_wd,
        input logic        w_we,
        input logic [4:0]  w_a3,
        input logic [31:0] w_wd
    );
        if (src == 5'd0)
            return '0;
        else if (e_we && (e_a3 == src))
            return e_wd;
        else if (m_we && (m_a3 == src))
            return m_wd;
        else if (w_we && (w_a3 == src))
            return w_wd;
        else
            return grf;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: counts cycles until each register's
// pending result reaches a forward port and raises stall when a source
// operand is needed before then.
module hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TNEW_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic       flush,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_a3,
    input  logic [1:0] id_tnew,
    output logic       stall
);

    localparam int unsigned CNT_MAX = (1 << TNEW_W) - 1;

    logic [TNEW_W-1:0] sb [32];
    logic [TNEW_W:0]   tnew_inc;
    logic [TNEW_W-1:0] issue_cnt;
    logic              hz_rs;
    logic              hz_rt;
    logic              issue;

    // Issue count is Tnew plus the ID/EX hop, saturated to the counter range
    always_comb begin
        tnew_inc  = (TNEW_W+1)'(id_tnew) + (TNEW_W+1)'(1);
        issue_cnt = tnew_inc[TNEW_W-1:0];
        if (32'(tnew_inc) > CNT_MAX)
            issue_cnt = TNEW_W'(CNT_MAX);
    end

    // Hazard when the operand is used before its producer can forward it
    always_comb begin
        hz_rs = id_valid && (id_rs != 5'd0) && (id_tuse_rs != TUSE_NONE) &&
                (32'(sb[id_rs]) > 32'(id_tuse_rs));
        hz_rt = id_valid && (id_rt != 5'd0) && (id_tuse_rt != TUSE_NONE) &&
                (32'(sb[id_rt]) > 32'(id_tuse_rt));
        stall = hz_rs || hz_rt;
        issue = id_valid && !stall && !flush && (id_a3 != 5'd0);
    end

    // Counters count down each cycle; an issue overrides its entry's decrement
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++)
                sb[i] <= '0;
        end else begin
            sb[0] <= '0;
            for (int unsigned i = 1; i < 32; i++) begin
                if (issue && (id_a3 == 5'(i)))
                    sb[i] <= issue_cnt;
                else if (sb[i] != '0)
                    sb[i] <= sb[i] - TNEW_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: register-file addressing, priority
// bypass from EX/MEM/WB, scoreboard stall, and the ID/EX register.
module id_operand_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TNEW_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic [4:0]  id_a3,
    input  logic [1:0]  id_tnew,
    input  logic        flush,
    output logic [4:0]  grf_a1,
    output logic [4:0]  grf_a2,
    input  logic [31:0] grf_rd1,
    input  logic [31:0] grf_rd2,
    input  logic        e_fwd_we,
    input  logic        m_fwd_we,
    input  logic        w_we,
    input  logic [4:0]  e_fwd_a3,
    input  logic [4:0]  m_fwd_a3,
    input  logic [4:0]  w_a3,
    input  logic [31:0] e_fwd_wd,
    input  logic [31:0] m_fwd_wd,
    input  logic [31:0] w_wd,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [4:0]  ex_a3,
    output logic [1:0]  ex_tnew
);

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    id_ex_t      id_ex;

    assign grf_a1 = id_rs;
    assign grf_a2 = id_rt;

    hazard_scoreboard #(
        .TNEW_W (TNEW_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .flush      (flush),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_a3      (id_a3),
        .id_tnew    (id_tnew),
        .stall      (stall)
    );

    // Resolve both operands through the bypass network
    always_comb begin
        rs_val = bypass(id_rs, grf_rd1, e_fwd_we, e_fwd_a3, e_fwd_wd,
                        m_fwd_we, m_fwd_a3, m_fwd_wd, w_we, w_a3, w_wd);
        rt_val = bypass(id_rt, grf_rd2, e_fwd_we, e_fwd_a3, e_fwd_wd,
                        m_fwd_we, m_fwd_a3, m_fwd_wd, w_we, w_a3, w_wd);
    end

    // ID/EX register: bubble on reset, stall, flush or empty slot
    always_ff @(posedge clk) begin
        if (!reset || stall || flush || !id_valid) begin
            id_ex <= '0;
        end else begin
            id_ex <= '{valid:  1'b1,
                       pc:     id_pc,
                       rs_val: rs_val,
                       rt_val: rt_val,
                       a3:     id_a3,
                       tnew:   id_tnew};
        end
    end

    assign ex_valid  = id_ex.valid;
    assign ex_pc     = id_ex.pc;
    assign ex_rs_val = id_ex.rs_val;
    assign ex_rt_val = id_ex.rt_val;
    assign ex_a3     = id_ex.a3;
    assign ex_tnew   = id_ex.tnew;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: expected ID/EX contents are
// queued at drive time and compared one cycle later.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_a3 = '0;
    logic [1:0]  id_tuse_rs = 2'd3, id_tuse_rt = 2'd3, id_tnew = '0;
    logic        flush = 1'b0;
    logic [4:0]  grf_a1, grf_a2;
    logic [31:0] grf_rd1 = '0, grf_rd2 = '0;
    logic        e_fwd_we = 1'b0, m_fwd_we = 1'b0, w_we = 1'b0;
    logic [4:0]  e_fwd_a3 = '0, m_fwd_a3 = '0, w_a3 = '0;
    logic [31:0] e_fwd_wd = '0, m_fwd_wd = '0, w_wd = '0;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val;
    logic [4:0]  ex_a3;
    logic [1:0]  ex_tnew;

    always #5 clk = ~clk;

    id_operand_stage #(
        .TNEW_W (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_a3      (id_a3),
        .id_tnew    (id_tnew),
        .flush      (flush),
        .grf_a1     (grf_a1),
        .grf_a2     (grf_a2),
        .grf_rd1    (grf_rd1),
        .grf_rd2    (grf_rd2),
        .e_fwd_we   (e_fwd_we),
        .m_fwd_we   (m_fwd_we),
        .w_we       (w_we),
        .e_fwd_a3   (e_fwd_a3),
        .m_fwd_a3   (m_fwd_a3),
        .w_a3       (w_a3),
        .e_fwd_wd   (e_fwd_wd),
        .m_fwd_wd   (m_fwd_wd),
        .w_wd       (w_wd),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_rs_val  (ex_rs_val),
        .ex_rt_val  (ex_rt_val),
        .ex_a3      (ex_a3),
        .ex_tnew    (ex_tnew)
    );

    typedef struct {
        logic        rst_n, valid, flush;
        logic [4:0]  rs, rt, a3;
        logic [1:0]  tu_rs, tu_rt, tnew;
        logic [31:0] rd1, rd2;
        logic        ewe, mwe, wwe;
        logic [4:0]  ea3, ma3, wa3;
        logic [31:0] ewd, mwd, wwd;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs_val, rt_val;
        logic [4:0]  a3;
        logic [1:0]  tnew;
    } exp_t;

    typedef struct {
        vec_t        v;
        logic [31:0] exp_rt;
    } prio_t;

    exp_t        exp_q [$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    function automatic vec_t base();
        vec_t v;
        v.rst_n = 1'b1; v.valid = 1'b1; v.flush = 1'b0;
        v.rs = '0; v.rt = '0; v.a3 = '0;
        v.tu_rs = 2'd3; v.tu_rt = 2'd3; v.tnew = '0;
        v.rd1 = 32'h1111_0001; v.rd2 = 32'h2222_0002;
        v.ewe = 1'b0; v.mwe = 1'b0; v.wwe = 1'b0;
        v.ea3 = '0; v.ma3 = '0; v.wa3 = '0;
        v.ewd = 32'hEEEE_0000; v.mwd = 32'hDDDD_0000; v.wwd = 32'hBBBB_0000;
        v.exp_stall = 1'b0;
        return v;
    endfunction

    // Reference bypass: $0, then EX, MEM, WB, then register file
    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] grf,
                                            input vec_t v);
        logic [31:0] r;
        r = grf;
        if (v.wwe && v.wa3 == src) r = v.wwd;
        if (v.mwe && v.ma3 == src) r = v.mwd;
        if (v.ewe && v.ea3 == src) r = v.ewd;
        if (src == 5'd0) r = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s pc=%h: got %h expected %h", name, pc_ctr, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst_n; id_valid = v.valid; flush = v.flush; id_pc = pc_ctr;
        id_rs = v.rs; id_rt = v.rt; id_a3 = v.a3;
        id_tuse_rs = v.tu_rs; id_tuse_rt = v.tu_rt; id_tnew = v.tnew;
        grf_rd1 = v.rd1; grf_rd2 = v.rd2;
        e_fwd_we = v.ewe; e_fwd_a3 = v.ea3; e_fwd_wd = v.ewd;
        m_fwd_we = v.mwe; m_fwd_a3 = v.ma3; m_fwd_wd = v.mwd;
        w_we = v.wwe; w_a3 = v.wa3; w_wd = v.wwd;
        #1;
        chk("stall", 32'(stall), 32'(v.exp_stall));
        chk("grf_a1", 32'(grf_a1), 32'(v.rs));
        chk("grf_a2", 32'(grf_a2), 32'(v.rt));
        if (!v.rst_n || v.exp_stall || v.flush || !v.valid) begin
            e.valid = 1'b0; e.pc = '0; e.rs_val = '0; e.rt_val = '0; e.a3 = '0; e.tnew = '0;
        end else begin
            e.valid = 1'b1; e.pc = pc_ctr;
            e.rs_val = ref_fwd(v.rs, v.rd1, v);
            e.rt_val = ref_fwd(v.rt, v.rd2, v);
            e.a3 = v.a3; e.tnew = v.tnew;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_rs_val", ex_rs_val, e.rs_val);
            chk("ex_rt_val", ex_rt_val, e.rt_val);
            chk("ex_a3", 32'(ex_a3), 32'(e.a3));
            chk("ex_tnew", 32'(ex_tnew), 32'(e.tnew));
        end
        pc_ctr += 32'd4;
    endtask

    initial begin
        vec_t  v;
        prio_t tbl [8];

        // Bypass priority vectors: rt=4 with no pending producer
        for (int i = 0; i < 8; i++) begin
            tbl[i].v = base();
            tbl[i].v.rt = 5'd4;
            tbl[i].v.tu_rt = 2'd1;
            tbl[i].v.ewd = 32'hA; tbl[i].v.mwd = 32'hB; tbl[i].v.wwd = 32'hC;
        end
        tbl[0].v.ewe = 1; tbl[0].v.ea3 = 4; tbl[0].v.mwe = 1; tbl[0].v.ma3 = 4;
        tbl[0].v.wwe = 1; tbl[0].v.wa3 = 4; tbl[0].exp_rt = 32'hA;
        tbl[1].v.wwe = 1; tbl[1].v.wa3 = 4; tbl[1].exp_rt = 32'hC;
        tbl[2].v.mwe = 1; tbl[2].v.ma3 = 4; tbl[2].v.wwe = 1; tbl[2].v.wa3 = 4;
        tbl[2].exp_rt = 32'hB;
        tbl[3].v.ewe = 0; tbl[3].v.ea3 = 4; tbl[3].v.mwe = 1; tbl[3].v.ma3 = 4;
        tbl[3].exp_rt = 32'hB;
        tbl[4].v.rt = 0; tbl[4].v.ewe = 1; tbl[4].v.mwe = 1; tbl[4].v.wwe = 1;
        tbl[4].exp_rt = 32'h0;
        tbl[5].exp_rt = 32'h2222_0002;
        tbl[6].v.rs = 4; tbl[6].v.tu_rs = 2'd0; tbl[6].v.ewe = 1; tbl[6].v.ea3 = 4;
        tbl[6].v.ma3 = 5; tbl[6].v.mwe = 1; tbl[6].exp_rt = 32'hA;
        tbl[7].v.valid = 0; tbl[7].v.ewe = 1; tbl[7].v.ea3 = 4; tbl[7].exp_rt = 32'h0;

        // Reset held two cycles, then the same read goes through
        v = base(); v.rst_n = 0; v.rs = 5; v.tu_rs = 2'd1;
        run(v); run(v);
        v.rst_n = 1; run(v);
        chk("reset_rs_grf", ex_rs_val, 32'h1111_0001);

        // Load-use: two stall cycles, then MEM forward
        v = base(); v.a3 = 8; v.tnew = 2; run(v);
        v = base(); v.rs = 8; v.tu_rs = 2'd1; v.exp_stall = 1; run(v); run(v);
        v.exp_stall = 0; v.mwe = 1; v.ma3 = 8; v.mwd = 32'h1234; run(v);
        chk("load_use_fwd", ex_rs_val, 32'h1234);

        // ALU-to-ALU: one stall cycle, then EX forward
        v = base(); v.a3 = 9; v.tnew = 1; run(v);
        v = base(); v.rs = 9; v.tu_rs = 2'd1; v.exp_stall = 1; run(v);
        v.exp_stall = 0; v.ewe = 1; v.ea3 = 9; v.ewd = 32'hCAFE_0001; run(v);
        chk("alu_fwd", ex_rs_val, 32'hCAFE_0001);

        foreach (tbl[i]) begin
            run(tbl[i].v);
            chk("prio_rt", ex_rt_val, tbl[i].exp_rt);
        end

        // Flush on a hazard cycle must not write the scoreboard
        v = base(); v.a3 = 10; v.tnew = 2; run(v);
        v = base(); v.rs = 10; v.tu_rs = 2'd0; v.a3 = 11; v.tnew = 1;
        v.flush = 1; v.exp_stall = 1; run(v);
        v = base(); v.rs = 11; v.tu_rs = 2'd0; run(v);
        v = base(); v.rs = 10; v.tu_rs = 2'd0; v.exp_stall = 1; run(v);
        v.exp_stall = 0; run(v);

        // Destination $0 never creates a hazard
        v = base(); v.a3 = 0; v.tnew = 2; run(v);
        v = base(); v.rs = 0; v.rt = 0; v.tu_rs = 2'd0; v.tu_rt = 2'd0; run(v);

        // Tnew=3 saturates the counter at 3 rather than wrapping
        v = base(); v.a3 = 12; v.tnew = 3; run(v);
        v = base(); v.rt = 12; v.tu_rt = 2'd2; v.exp_stall = 1; run(v);
        v.exp_stall = 0; run(v);

        // Back-to-back issues to the same register: newer count wins
        v = base(); v.a3 = 13; v.tnew = 1; run(v);
        v.tnew = 2; run(v);
        v = base(); v.rs = 13; v.tu_rs = 2'd1; v.exp_stall = 1; run(v); run(v);
        v.exp_stall = 0; run(v);

        // Reset during a stall clears the scoreboard
        v = base(); v.a3 = 7; v.tnew = 2; run(v);
        v = base(); v.rs = 7; v.tu_rs = 2'd0; v.rst_n = 0; v.exp_stall = 1; run(v);
        v.rst_n = 1; v.exp_stall = 0; run(v);
        chk("post_reset_rs", ex_rs_val, 32'h1111_0001);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
